mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: default widths, the
// starvation counter width and the read-owner state enumeration.
package mem_arb_pkg;

  localparam int unsigned AW_DEFAULT = 9;
  localparam int unsigned DW_DEFAULT = 16;

  // Width of the port 1 starvation counter; MAX_WAIT must fit in it.
  localparam int unsigned WAIT_W = 4;

  // Owner of the read currently in flight to the RAM.
  typedef enum logic [1:0] {
    IDLE,
    RD0,
    RD1
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port RAM with a registered read
// path. One access is granted per cycle; read data returns one cycle after
// the grant to the port that issued it.
//
// Build option: define ARB_ROUND_ROBIN_EN to replace fixed priority (port 0
// first, port 1 forced after MAX_WAIT denials) with round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW       = AW_DEFAULT,
  parameter int unsigned DW       = DW_DEFAULT,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_rvalid,

  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_rvalid,

  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  logic          gnt0, gnt1;
  owner_e        owner_q;
  logic [DW-1:0] hold0_q, hold1_q;

`ifdef ARB_ROUND_ROBIN_EN

  // 1 means port 1 received the most recent grant.
  logic last_q;

  // Round-robin grant: on contention the port not granted last wins.
  always_comb begin
    gnt1 = ~reset & p1_req & (~p0_req | ~last_q);
    gnt0 = ~reset & p0_req & ~gnt1;
  end

  // Remember which port was granted last; reset favours port 0 next.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (gnt0) begin
      last_q <= 1'b0;
    end else if (gnt1) begin
      last_q <= 1'b1;
    end
  end

`else

  logic [WAIT_W-1:0] wait_q;
  logic              force_p1;

  assign force_p1 = (wait_q == WAIT_W'(MAX_WAIT));

  // Fixed priority grant: port 0 wins unless port 1 has starved too long.
  always_comb begin
    gnt1 = ~reset & p1_req & (~p0_req | force_p1);
    gnt0 = ~reset & p0_req & ~gnt1;
  end

  // Count consecutive denied port 1 requests; it cannot pass MAX_WAIT since
  // reaching it forces a grant.
  always_ff @(posedge clk) begin
    if (reset || !p1_req || gnt1) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_q + WAIT_W'(1);
    end
  end

`endif

  // Route the granted port onto the RAM bus; idle bus drives zeros.
  always_comb begin
    p0_gnt    = gnt0;
    p1_gnt    = gnt1;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (gnt0) begin
      ram_addr  = p0_addr;
      ram_we    = p0_we;
      ram_wdata = p0_wdata;
    end else if (gnt1) begin
      ram_addr  = p1_addr;
      ram_we    = p1_we;
      ram_wdata = p1_wdata;
    end
  end

  // Owner FSM: records which port's read is returning next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= IDLE;
    end else if (gnt0 && !p0_we) begin
      owner_q <= RD0;
    end else if (gnt1 && !p1_we) begin
      owner_q <= RD1;
    end else begin
      owner_q <= IDLE;
    end
  end

  // Read return decode; reset squashes a read that is still in flight.
  always_comb begin
    p0_rvalid = ~reset & (owner_q == RD0);
    p1_rvalid = ~reset & (owner_q == RD1);
    p0_rdata  = reset ? '0 : (p0_rvalid ? ram_rdata : hold0_q);
    p1_rdata  = reset ? '0 : (p1_rvalid ? ram_rdata : hold1_q);
  end

  // Keep the last returned word per port so rdata holds between returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      if (p0_rvalid) hold0_q <= ram_rdata;
      if (p1_rvalid) hold1_q <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: an external RAM model, a cycle-level reference
// model checked on every cycle, and directed scenarios with literal values.
module tb_mem_arbiter;

  localparam int AW       = 9;
  localparam int DW       = 16;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  mem_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_gnt    (p0_gnt),
    .p0_rdata  (p0_rdata),
    .p0_rvalid (p0_rvalid),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_gnt    (p1_gnt),
    .p1_rdata  (p1_rdata),
    .p1_rvalid (p1_rvalid),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Power-up RAM contents; address 0x0F holds 0x0004.
  function automatic logic [DW-1:0] init_val(input int a);
    return (a == 15) ? 16'h0004 : (DW'(a) ^ 16'hA5A5);
  endfunction

  // External RAM: synchronous write, registered read.
  logic [DW-1:0] ram_mem [512];
  bit            ram_wr  [512];
  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
      ram_wr[ram_addr]  <= 1'b1;
    end
    ram_rdata <= ram_wr[ram_addr] ? ram_mem[ram_addr] : init_val(int'(ram_addr));
  end

  // Reference model state: state seen by the cycle being checked.
  int            m_wait  = 0;
  bit            m_last  = 1'b1;
  int            m_pend  = -1;
  logic [DW-1:0] m_pdata = '0;
  logic [DW-1:0] m_hold0 = '0;
  logic [DW-1:0] m_hold1 = '0;
  logic [DW-1:0] sh_mem [512];
  bit            sh_wr  [512];

  logic          e_g0, e_g1, e_rv0, e_rv1, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_rd0, e_rd1;

  // Compare every cycle, then advance the model past the coming edge.
  always @(negedge clk) begin
    e_g0 = 1'b0; e_g1 = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0;
    e_addr = '0; e_we = 1'b0; e_wd = '0; e_rd0 = '0; e_rd1 = '0;
    if (!reset) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (p0_req && p1_req) begin
        if (m_last) e_g0 = 1'b1;
        else        e_g1 = 1'b1;
      end else begin
        e_g0 = p0_req;
        e_g1 = p1_req;
      end
`else
      if (p1_req && (!p0_req || m_wait == MAX_WAIT)) e_g1 = 1'b1;
      else                                           e_g0 = p0_req;
`endif
      e_rv0 = (m_pend == 0);
      e_rv1 = (m_pend == 1);
      e_rd0 = e_rv0 ? m_pdata : m_hold0;
      e_rd1 = e_rv1 ? m_pdata : m_hold1;
      if (e_g0) begin
        e_addr = p0_addr; e_we = p0_we; e_wd = p0_wdata;
      end else if (e_g1) begin
        e_addr = p1_addr; e_we = p1_we; e_wd = p1_wdata;
      end
    end

    check("gnt0",      32'(p0_gnt),    32'(e_g0));
    check("gnt1",      32'(p1_gnt),    32'(e_g1));
    check("rvalid0",   32'(p0_rvalid), 32'(e_rv0));
    check("rvalid1",   32'(p1_rvalid), 32'(e_rv1));
    check("rdata0",    32'(p0_rdata),  32'(e_rd0));
    check("rdata1",    32'(p1_rdata),  32'(e_rd1));
    check("ram_addr",  32'(ram_addr),  32'(e_addr));
    check("ram_we",    32'(ram_we),    32'(e_we));
    check("ram_wdata", 32'(ram_wdata), 32'(e_wd));

    if (reset) begin
      m_wait = 0; m_last = 1'b1; m_pend = -1; m_hold0 = '0; m_hold1 = '0;
    end else begin
      if (e_rv0) m_hold0 = m_pdata;
      if (e_rv1) m_hold1 = m_pdata;
      m_pend = -1;
      if (e_g0 || e_g1) begin
        if (!e_we) begin
          m_pend  = e_g0 ? 0 : 1;
          m_pdata = sh_wr[e_addr] ? sh_mem[e_addr] : init_val(int'(e_addr));
        end else begin
          sh_mem[e_addr] = e_wd;
          sh_wr[e_addr]  = 1'b1;
        end
      end
      m_wait = (!p1_req || e_g1) ? 0 : m_wait + 1;
      if (e_g0)      m_last = 1'b0;
      else if (e_g1) m_last = 1'b1;
    end
  end

  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic r1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with both ports requesting: no grants may appear.
    reset = 1'b1;
    drive(1'b1, 1'b0, 9'h003, 16'h0, 1'b1, 1'b1, 9'h004, 16'h1234);
    @(negedge clk);
    check("rst_gnt0", 32'(p0_gnt), 32'd0);
    check("rst_gnt1", 32'(p1_gnt), 32'd0);
    check("rst_rdata0", 32'(p0_rdata), 32'd0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    idle();

    // Three idle cycles: quiet RAM bus, no returns.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_we", 32'(ram_we), 32'd0);
      check("idle_addr", 32'(ram_addr), 32'd0);
      check("idle_rv", 32'({p0_rvalid, p1_rvalid}), 32'd0);
      next_cycle();
    end

    // Port 0 reads 0x0F, which holds 0x0004.
    drive(1'b1, 1'b0, 9'h00F, 16'h0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("rd0_gnt", 32'(p0_gnt), 32'd1);
    check("rd0_addr", 32'(ram_addr), 32'h0F);
    next_cycle();
    idle();
    @(negedge clk);
    check("rd0_rvalid", 32'(p0_rvalid), 32'd1);
    check("rd0_rdata", 32'(p0_rdata), 32'h0004);
    check("rd0_rv1", 32'(p1_rvalid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("rd0_after", 32'(p0_rvalid), 32'd0);
    check("rd0_hold", 32'(p0_rdata), 32'h0004);
    next_cycle();

    // Port 1 writes 900 to 0x14, then reads it straight back.
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 9'h014, 16'd900);
    @(negedge clk);
    check("wr1_gnt", 32'(p1_gnt), 32'd1);
    check("wr1_we", 32'(ram_we), 32'd1);
    check("wr1_wdata", 32'(ram_wdata), 32'd900);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 9'h014, 16'h0);
    @(negedge clk);
    check("raw_we", 32'(ram_we), 32'd0);
    check("raw_gnt", 32'(p1_gnt), 32'd1);
    check("raw_norv", 32'(p1_rvalid), 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    check("raw_rvalid", 32'(p1_rvalid), 32'd1);
    check("raw_rdata", 32'(p1_rdata), 32'd900);
    next_cycle();

    // Continuous contention from reset.
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    drive(1'b1, 1'b0, 9'h001, 16'h0, 1'b1, 1'b0, 9'h002, 16'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
      check("rr_gnt1", 32'(p1_gnt), 32'((i % 2) == 1));
      check("rr_gnt0", 32'(p0_gnt), 32'((i % 2) == 0));
`else
      check("fp_gnt1", 32'(p1_gnt), 32'((i % 5) == 4));
      check("fp_gnt0", 32'(p0_gnt), 32'((i % 5) != 4));
`endif
      next_cycle();
    end

    // Reset lands the cycle after a granted port 0 read.
    drive(1'b1, 1'b0, 9'h00F, 16'h0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("rst_rd_gnt", 32'(p0_gnt), 32'd1);
    next_cycle();
    reset = 1'b1;
    drive(1'b1, 1'b0, 9'h005, 16'h0, 1'b1, 1'b0, 9'h006, 16'h0);
    @(negedge clk);
    check("rst_rd_rv", 32'(p0_rvalid), 32'd0);
    check("rst_rd_out", 32'({p0_gnt, p1_gnt, p1_rvalid, ram_we}), 32'd0);
    check("rst_rd_bus", 32'(ram_addr) | 32'(ram_wdata), 32'd0);
    check("rst_rd_data", 32'(p0_rdata) | 32'(p1_rdata), 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_g0", 32'(p0_gnt), 32'd1);
    check("post_rst_g1", 32'(p1_gnt), 32'd0);
    next_cycle();

    // Mixed traffic over a small address window, with occasional resets.
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
            DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 7)), DW'($urandom));
      next_cycle();
    end
    reset = 1'b0;
    idle();
    next_cycle();
    next_cycle();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
